// File: rtl/deck_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : deck_pkg                                                         |
// | Brief   : Card word layout, deck constants and FSM states for deck_memory. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package deck_pkg;

  localparam int DECK_SIZE = 52;
  localparam int SUIT_MSB  = 6;
  localparam int SUIT_LSB  = 5;
  localparam int USED_BIT  = 4;
  localparam int RANK_MSB  = 3;
  localparam int RANK_LSB  = 0;

  typedef enum logic [1:0] {
    HEARTS   = 2'd0,
    DIAMONDS = 2'd1,
    CLUBS    = 2'd2,
    SPADES   = 2'd3
  } suit_t;

  typedef struct packed {
    suit_t      suit;
    logic       used;
    logic [3:0] rank;
  } card_t;

  localparam logic [6:0] OOR_WORD = 7'h10;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } deck_state_t;

  // Slot idx of an ordered deck: 13 ranks (1..13) per suit, all undrawn.
  function automatic logic [6:0] init_card(input logic [5:0] idx);
    card_t card;
    card.suit = suit_t'(2'(idx / 6'd13));
    card.used = 1'b0;
    card.rank = 4'((idx % 6'd13) + 6'd1);
    return card;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deck_ram_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : deck_ram_core                                                    |
// | Brief   : Single-port synchronous array with registered read data.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module deck_ram_core #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read register samples the pre-write word, giving read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/deck_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : deck_memory                                                      |
// | Brief   : Deck store with INIT sequencer, range check and undrawn count.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module deck_memory #(
  parameter int DECK_SIZE = deck_pkg::DECK_SIZE,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_deck,
  input  logic [ADDR_W-1:0] deck_addr,
  input  logic              deck_read_en,
  input  logic              deck_write_en,
  input  logic [DATA_W-1:0] deck_write_data,
  output logic [DATA_W-1:0] deck_read_data,
  output logic              deck_busy,
  output logic [5:0]        cards_left,
  output logic              deck_empty
);

  import deck_pkg::*;

  localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DECK_SIZE - 1);
  localparam logic [5:0]        c_full_cnt  = 6'(DECK_SIZE);

  deck_state_t       r_state;
  logic [ADDR_W-1:0] r_init_idx;
  logic              r_busy;
  logic [5:0]        r_cards_left;
  logic              r_oor_rd;
  logic [2**ADDR_W-1:0] r_used;

  logic              w_ready;
  logic              w_in_range;
  logic              w_init_wr;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_old_used;
  logic              w_new_used;
  logic              w_dec;
  logic              w_inc;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_ready    = (r_state == READY);
  assign w_in_range = (deck_addr <= c_last_idx);
  assign w_init_wr  = !w_ready && !new_deck;
  assign w_rd_acc   = w_ready && !new_deck && deck_read_en;
  assign w_wr_acc   = w_ready && !new_deck && deck_write_en && w_in_range;

  assign w_ram_addr  = w_ready ? deck_addr : r_init_idx;
  assign w_ram_wdata = w_ready ? deck_write_data : DATA_W'(init_card(6'(r_init_idx)));

  // Used flags are shadowed in flops so the count can see the old flag on the write edge.
  assign w_old_used = r_used[deck_addr];
  assign w_new_used = deck_write_data[USED_BIT];
  assign w_dec      = w_wr_acc && !w_old_used &&  w_new_used;
  assign w_inc      = w_wr_acc &&  w_old_used && !w_new_used;

  deck_ram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .addr  (w_ram_addr),
    .we    (w_init_wr || w_wr_acc),
    .wdata (w_ram_wdata),
    .re    (w_rd_acc && w_in_range),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_used[r_init_idx] <= 1'b0;
    end else if (w_wr_acc) begin
      r_used[deck_addr] <= w_new_used;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oor_rd <= 1'b0;
    end else if (w_rd_acc) begin
      r_oor_rd <= !w_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= INIT;
      r_init_idx   <= '0;
      r_busy       <= 1'b1;
      r_cards_left <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (new_deck) begin
            r_init_idx <= '0;
          end else if (r_init_idx == c_last_idx) begin
            r_state      <= READY;
            r_init_idx   <= '0;
            r_busy       <= 1'b0;
            r_cards_left <= c_full_cnt;
          end else begin
            r_init_idx <= r_init_idx + 1'b1;
          end
        end
        READY: begin
          if (new_deck) begin
            r_state      <= INIT;
            r_init_idx   <= '0;
            r_busy       <= 1'b1;
            r_cards_left <= '0;
          end else if (w_dec) begin
            r_cards_left <= r_cards_left - 1'b1;
          end else if (w_inc) begin
            r_cards_left <= r_cards_left + 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_dec && r_cards_left == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_inc && r_cards_left == c_full_cnt));

  assign deck_read_data = r_oor_rd ? DATA_W'(OOR_WORD) : w_ram_rdata;
  assign deck_busy      = r_busy;
  assign cards_left     = r_cards_left;
  assign deck_empty     = (r_cards_left == '0) && !r_busy;

endmodule
`default_nettype wire
